exec_mc_stage: RTL and testbench
================================

// Module: exec_mc_stage
// PURPOSE
//  Parametrised execute stage with an integrated EX/MEM output register. Single-cycle ALU ops
//  complete in 1 cycle; MUL/DIVU/REMU run on an iterative 1-bit-per-cycle engine under an FSM.
//  Sits between the decode/forwarding logic (which supplies already-forwarded operands) and the memory stage.
//  Exposes ready/valid handshakes so hazard logic can stall fetch/decode while a multi-cycle op runs.
// PARAMETERS
//  N     24  datapath width (bits), >= 4
//  RW    4   destination register index width
//  SB_W  16  sideband width (opType/opCode/branch/mem/regWrite bits), carried through untouched
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous reset, active-low
//  en            in   1     downstream advance; 0 = hold output register (stall)
//  flush         in   1     kill in-flight op and output register contents
//  in_valid      in   1     operands/controls below are a real instruction
//  in_ready      out  1     stage accepts an instruction this cycle
//  op_a, op_b    in   N     forwarded ALU operands
//  store_data    in   N     forwarded store data (rd3 path)
//  alu_ctrl      in   4     operation code (see BEHAVIOUR)
//  rc            in   RW    destination register index
//  sideband      in   SB_W  pass-through control bits
//  out_valid     out  1     output register holds a completed instruction
//  out_result    out  N     ALU/MUL/DIV result
//  out_zero      out  1     out_result == 0
//  out_neg       out  1     out_result[N-1]
//  out_rc        out  RW    registered rc
//  out_store     out  N     registered store_data
//  out_sideband  out  SB_W  registered sideband
//  busy          out  1     FSM not IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, FSM=IDLE, iteration counter 0; in_ready=0 while rst=0.
//  - alu_ctrl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 SRA (shift amount =
//    op_b mod N), 8 SLT (signed, 1/0), 9 PASS_B, A MUL (low N bits), B DIVU, C REMU, D-F -> result 0.
//  - All arithmetic is modulo 2^N; no overflow flag; out_zero/out_neg derive from the final result.
//  - in_ready = (state==IDLE) & en & rst. Accept = in_valid & in_ready.
//  - Single-cycle op accepted at edge k -> out_valid=1 with result, rc, store, sideband at edge k+1.
//  - Multi-cycle op: IDLE -> RUN on accept, latching operands/rc/store/sideband; RUN for exactly N
//    cycles (counter N-1..0); RUN -> DONE; DONE -> IDLE loading the output register when en=1,
//    else stays in DONE. Latency accept->out_valid = N+1 cycles with en held 1.
//  - While not IDLE: in_ready=0; output register loads out_valid=0 (bubble) on each en=1 cycle.
//  - DIVU/REMU by zero: quotient = all ones, remainder = op_a. MUL/DIV operands are unsigned.
//  - en=0: output register and FSM state (IDLE/DONE) hold; RUN iterations continue and park in DONE.
//  - flush=1 (sync, beats en and in_valid): next edge out_valid=0, other outputs 0, FSM -> IDLE,
//    no accept that cycle.
//  - No accept and en=1 -> out_valid=0 next edge (bubble).
// TESTING
//  1 N=24: ADD a=5 b=7, en=1 -> next cycle out_valid=1, out_result=12, out_zero=0.
//  2 SUB a=3 b=3 -> out_result=0, out_zero=1; SUB a=0 b=1 -> 0xFFFFFF, out_neg=1.
//  3 MUL a=1000 b=3000 -> busy/in_ready=0 for 24 cycles, out_valid=1 at cycle 25, result 3000000.
//  4 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFF; REMU 9/0 -> 9.
//  5 flush asserted at RUN cycle 10 of a MUL -> next edge out_valid=0, busy=0, in_ready=1.
//  6 ADD result present, then en=0 for 3 cycles with new in_valid -> outputs stable, in_ready=0;
//    rst pulled low mid-DIVU -> all outputs 0 immediately, FSM=IDLE.

Source files
------------

// File: rtl/exec_mc_stage.sv
// Execute stage with EX/MEM output register: single-cycle ALU plus an iterative
// 1-bit-per-cycle MUL/DIVU/REMU engine sequenced by an IDLE/RUN/DONE FSM.
module exec_mc_stage #(
  parameter int N    = 24,
  parameter int RW   = 4,
  parameter int SB_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    op_a,
  input  logic [N-1:0]    op_b,
  input  logic [N-1:0]    store_data,
  input  logic [3:0]      alu_ctrl,
  input  logic [RW-1:0]   rc,
  input  logic [SB_W-1:0] sideband,
  output logic            out_valid,
  output logic [N-1:0]    out_result,
  output logic            out_zero,
  output logic            out_neg,
  output logic [RW-1:0]   out_rc,
  output logic [N-1:0]    out_store,
  output logic [SB_W-1:0] out_sideband,
  output logic            busy
);
  localparam int CW = $clog2(N);
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hB;
  localparam logic [3:0] OP_REMU = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_acc;
  logic [N-1:0]    r_mcand;
  logic [N-1:0]    r_mplier;
  logic [3:0]      r_op;
  logic [RW-1:0]   r_rc;
  logic [N-1:0]    r_store;
  logic [SB_W-1:0] r_sb;

  logic            w_multi;
  logic            w_accept;
  logic            w_start;
  logic [N-1:0]    w_alu;
  logic [N-1:0]    w_mc_res;
  logic [N:0]      w_rsh;
  logic [N-1:0]    w_rdiff;
  logic            w_ge;

  function automatic logic [N-1:0] alu_f(input logic [3:0] ctrl,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [N-1:0] sh;
    sh = b % N'(N);
    case (ctrl)
      4'h0:    alu_f = a + b;
      4'h1:    alu_f = a - b;
      4'h2:    alu_f = a & b;
      4'h3:    alu_f = a | b;
      4'h4:    alu_f = a ^ b;
      4'h5:    alu_f = a << sh;
      4'h6:    alu_f = a >> sh;
      4'h7:    alu_f = $unsigned($signed(a) >>> sh);
      4'h8:    alu_f = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      4'h9:    alu_f = b;
      default: alu_f = '0;
    endcase
  endfunction

  assign in_ready = (r_state == S_IDLE) & en & rst;
  assign busy     = (r_state != S_IDLE);
  assign w_multi  = (alu_ctrl == OP_MUL) | (alu_ctrl == OP_DIVU) | (alu_ctrl == OP_REMU);
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_start  = w_accept & w_multi;
  assign w_alu    = alu_f(alu_ctrl, op_a, op_b);

  // Restoring divide step: partial remainder shifted left by one dividend bit
  assign w_rsh    = {r_acc, r_mplier[N-1]};
  assign w_ge     = (w_rsh >= {1'b0, r_mcand});
  assign w_rdiff  = w_rsh[N-1:0] - r_mcand;
  assign w_mc_res = (r_op == OP_DIVU) ? r_mplier : r_acc;

  // Control: FSM and EX/MEM output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_neg      <= 1'b0;
      out_rc       <= '0;
      out_store    <= '0;
      out_sideband <= '0;
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_neg      <= 1'b0;
      out_rc       <= '0;
      out_store    <= '0;
      out_sideband <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_cnt   <= CW'(N - 1);
          end
        end
        S_RUN: begin
          if (r_cnt == '0) r_state <= S_DONE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_DONE: begin
          if (en) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Bubbles only drop valid; payload fields keep their last contents
      if (en) begin
        if (r_state == S_DONE) begin
          out_valid    <= 1'b1;
          out_result   <= w_mc_res;
          out_zero     <= (w_mc_res == '0);
          out_neg      <= w_mc_res[N-1];
          out_rc       <= r_rc;
          out_store    <= r_store;
          out_sideband <= r_sb;
        end else if (w_accept && !w_multi) begin
          out_valid    <= 1'b1;
          out_result   <= w_alu;
          out_zero     <= (w_alu == '0);
          out_neg      <= w_alu[N-1];
          out_rc       <= rc;
          out_store    <= store_data;
          out_sideband <= sideband;
        end else begin
          out_valid    <= 1'b0;
        end
      end
    end
  end

  // Iterative engine datapath: MUL shifts multiplier right, DIV shifts dividend left
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_op    <= alu_ctrl;
      r_rc    <= rc;
      r_store <= store_data;
      r_sb    <= sideband;
      r_acc   <= '0;
      if (alu_ctrl == OP_MUL) begin
        r_mcand  <= op_a;
        r_mplier <= op_b;
      end else begin
        r_mcand  <= op_b;
        r_mplier <= op_a;
      end
    end else if (r_state == S_RUN) begin
      if (r_op == OP_MUL) begin
        r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end else begin
        r_acc    <= w_ge ? w_rdiff : w_rsh[N-1:0];
        r_mplier <= {r_mplier[N-2:0], w_ge};
      end
    end
  end
endmodule

// File: tb/tb_exec_mc_stage.sv
// Randomized and directed bench for exec_mc_stage against an arithmetic reference model.
module tb_exec_mc_stage;
  localparam int N    = 24;
  localparam int RW   = 4;
  localparam int SB_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [N-1:0]    store_data;
  logic [3:0]      alu_ctrl;
  logic [RW-1:0]   rc;
  logic [SB_W-1:0] sideband;
  logic            out_valid;
  logic [N-1:0]    out_result;
  logic            out_zero;
  logic            out_neg;
  logic [RW-1:0]   out_rc;
  logic [N-1:0]    out_store;
  logic [SB_W-1:0] out_sideband;
  logic            busy;

  int total = 0;
  int bad   = 0;

  exec_mc_stage #(.N(N), .RW(RW), .SB_W(SB_W)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .store_data(store_data),
    .alu_ctrl(alu_ctrl), .rc(rc), .sideband(sideband),
    .out_valid(out_valid), .out_result(out_result), .out_zero(out_zero),
    .out_neg(out_neg), .out_rc(out_rc), .out_store(out_store),
    .out_sideband(out_sideband), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input int ctrl, input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned ua, ub, m, sh, r;
    longint sa, sb, t;
    ua = a;
    ub = b;
    m  = (64'd1 << N) - 1;
    sa = longint'(ua) - (a[N-1] ? longint'(64'd1 << N) : 0);
    sb = longint'(ub) - (b[N-1] ? longint'(64'd1 << N) : 0);
    sh = ub % N;
    case (ctrl)
      0:  r = (ua + ub) & m;
      1:  r = (ua - ub) & m;
      2:  r = ua & ub;
      3:  r = ua | ub;
      4:  r = ua ^ ub;
      5:  r = (ua << sh) & m;
      6:  r = ua >> sh;
      7:  begin t = sa >>> sh; r = longint'(t) & m; end
      8:  r = (sa < sb) ? 1 : 0;
      9:  r = ub;
      10: r = (ua * ub) & m;
      11: r = (ub == 0) ? m : ua / ub;
      12: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    return r[N-1:0];
  endfunction

  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0]    exp;
    logic [RW-1:0]   xrc;
    logic [N-1:0]    xst;
    logic [SB_W-1:0] xsb;
    int              lat;
    bit              multi;
    bit              ok_busy;
    exp   = model(int'(ctrl), a, b);
    xrc   = RW'($urandom);
    xst   = N'($urandom);
    xsb   = SB_W'($urandom);
    multi = (ctrl == 4'hA) || (ctrl == 4'hB) || (ctrl == 4'hC);
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    rc = xrc; store_data = xst; sideband = xsb;
    @(negedge clk);
    in_valid = 1'b0; op_a = N'($urandom); op_b = N'($urandom);
    rc = RW'($urandom); store_data = N'($urandom); sideband = SB_W'($urandom);
    lat = 0;
    ok_busy = 1'b1;
    if (multi) begin
      while (!out_valid && lat < 100) begin
        if (lat < N && (busy !== 1'b1 || in_ready !== 1'b0)) ok_busy = 1'b0;
        @(negedge clk);
        lat++;
      end
      chk({tag, "_busy"}, 64'(ok_busy), 64'd1);
    end
    chk({tag, "_lat"}, 64'(lat), multi ? 64'(N + 1) : 64'd0);
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_res"}, 64'(out_result), 64'(exp));
    chk({tag, "_zero"}, 64'(out_zero), 64'(exp == '0));
    chk({tag, "_neg"}, 64'(out_neg), 64'(exp[N-1]));
    chk({tag, "_rc"}, 64'(out_rc), 64'(xrc));
    chk({tag, "_st"}, 64'(out_store), 64'(xst));
    chk({tag, "_sb"}, 64'(out_sideband), 64'(xsb));
  endtask

  initial begin
    logic [3:0]   c;
    logic [N-1:0] a, b;
    bit           stray;
    rst = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    op_a = '0; op_b = '0; store_data = '0; alu_ctrl = '0; rc = '0; sideband = '0;

    @(negedge clk);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(out_result), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    rst = 1'b1;

    run_op("add", 4'h0, 24'd5, 24'd7);
    run_op("sub0", 4'h1, 24'd3, 24'd3);
    run_op("subneg", 4'h1, 24'd0, 24'd1);
    run_op("mul", 4'hA, 24'd1000, 24'd3000);
    run_op("divu", 4'hB, 24'd100, 24'd7);
    run_op("remu", 4'hC, 24'd100, 24'd7);
    run_op("divz", 4'hB, 24'd9, 24'd0);
    run_op("remz", 4'hC, 24'd9, 24'd0);
    run_op("sra", 4'h7, 24'h800010, 24'd28);
    run_op("slt", 4'h8, 24'hFFFFFF, 24'd1);

    // Multi-cycle op with en low parks in DONE until en returns
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'hA; op_a = 24'd123; op_b = 24'd456;
    @(negedge clk);
    in_valid = 1'b0; en = 1'b0;
    repeat (N + 5) @(negedge clk);
    chk("park_busy", 64'(busy), 64'd1);
    chk("park_vld", 64'(out_valid), 64'd0);
    en = 1'b1;
    @(negedge clk);
    chk("park_out", 64'(out_valid), 64'd1);
    chk("park_res", 64'(out_result), 64'(model(10, 24'd123, 24'd456)));

    // Flush during RUN
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'hA; op_a = 24'd77; op_b = 24'd99;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_vld", 64'(out_valid), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    chk("fl_res", 64'(out_result), 64'd0);
    stray = 1'b0;
    repeat (N + 3) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    chk("fl_stray", 64'(stray), 64'd0);

    // Stall holds the output register and blocks new instructions
    run_op("add6", 4'h0, 24'd100, 24'd23);
    en = 1'b0; in_valid = 1'b1; alu_ctrl = 4'h1; op_a = 24'd9; op_b = 24'd4;
    repeat (3) begin
      @(negedge clk);
      chk("stall_vld", 64'(out_valid), 64'd1);
      chk("stall_res", 64'(out_result), 64'd123);
      chk("stall_rdy", 64'(in_ready), 64'd0);
    end
    en = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("bubble", 64'(out_valid), 64'd0);

    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = N'($urandom);
      b = N'($urandom);
      if (c == 4'hB || c == 4'hC) begin
        if ($urandom_range(0, 3) == 0) b = '0;
        else if ($urandom_range(0, 1) == 0) b = N'($urandom_range(1, 300));
      end
      run_op("rnd", c, a, b);
    end

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'hB; op_a = 24'd5000; op_b = 24'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", 64'(out_valid), 64'd0);
    chk("arst_res", 64'(out_result), 64'd0);
    chk("arst_rc", 64'(out_rc), 64'd0);
    chk("arst_st", 64'(out_store), 64'd0);
    chk("arst_sb", 64'(out_sideband), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("post", 4'hB, 24'd5000, 24'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
